// File: rtl/sensor_estacionamiento.sv
// Multi-bay two-beam parking sensor: per-bay sync + debounce + entry/exit FSM with
// manoeuvre timeout, plus occupancy count, entry total and sticky error flags.
module sensor_estacionamiento #(
  parameter int N_BAYS   = 4,
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_BAYS-1:0]            a,
  input  logic [N_BAYS-1:0]            b,
  input  logic                         clr_error,
  output logic [N_BAYS-1:0]            ingreso,
  output logic [N_BAYS-1:0]            egreso,
  output logic [N_BAYS-1:0]            ocupado,
  output logic [N_BAYS-1:0]            error,
  output logic [N_BAYS-1:0]            error_sticky,
  output logic [$clog2(N_BAYS+1)-1:0]  ocupados,
  output logic [CNT_W-1:0]             total_ingresos
);

  localparam int  OCC_W      = $clog2(N_BAYS + 1);
  localparam int  DB_W       = $clog2(DEBOUNCE + 1);
  localparam int  TM_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int  TM_LIM     = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit  TIMEOUT_EN = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    VACIO, ENTRANDO, ESTACIONADO, SALIENDO, INVALIDO
  } bay_state_t;

  function automatic logic [OCC_W-1:0] popcount(input logic [N_BAYS-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int j = 0; j < N_BAYS; j++) n = n + OCC_W'(v[j]);
    return n;
  endfunction

  for (genvar i = 0; i < N_BAYS; i++) begin : g_bay
    logic [1:0]      sync1, sync2, candidate, sensed;
    logic [DB_W-1:0] db_cnt, db_cnt_next;
    logic [TM_W-1:0] timer;
    bay_state_t      state, state_next;
    logic            ing_q, egr_q, ing_next, egr_next;
    logic            timed_out;

    // The count restarts at 1 because the differing sample is itself the first of the run.
    always_comb begin
      db_cnt_next = db_cnt;
      if (sync2 != candidate)
        db_cnt_next = DB_W'(1);
      else if (db_cnt < DB_W'(DEBOUNCE))
        db_cnt_next = db_cnt + 1'b1;
    end

    assign timed_out = TIMEOUT_EN && (timer >= TM_W'(TM_LIM));

    always_comb begin
      state_next = state;
      ing_next   = 1'b0;
      egr_next   = 1'b0;
      case (state)
        VACIO: begin
          if (sensed == 2'b10)
            state_next = ENTRANDO;
          else if (sensed == 2'b11 || sensed == 2'b01)
            state_next = INVALIDO;
        end
        ENTRANDO: begin
          case (sensed)
            2'b11: begin
              state_next = ESTACIONADO;
              ing_next   = 1'b1;
            end
            2'b00:   state_next = VACIO;
            2'b01:   state_next = INVALIDO;
            default: if (timed_out) state_next = INVALIDO;
          endcase
        end
        ESTACIONADO: begin
          if (sensed == 2'b10)
            state_next = SALIENDO;
          else if (sensed == 2'b00 || sensed == 2'b01)
            state_next = INVALIDO;
        end
        SALIENDO: begin
          case (sensed)
            2'b00: begin
              state_next = VACIO;
              egr_next   = 1'b1;
            end
            2'b11:   state_next = ESTACIONADO;
            2'b01:   state_next = INVALIDO;
            default: if (timed_out) state_next = INVALIDO;
          endcase
        end
        INVALIDO: begin
          if (sensed == 2'b00) state_next = VACIO;
        end
        default: state_next = VACIO;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1     <= 2'b00;
        sync2     <= 2'b00;
        candidate <= 2'b00;
        sensed    <= 2'b00;
        db_cnt    <= '0;
        timer     <= '0;
        state     <= VACIO;
        ing_q     <= 1'b0;
        egr_q     <= 1'b0;
      end else begin
        sync1     <= {a[i], b[i]};
        sync2     <= sync1;
        candidate <= sync2;
        db_cnt    <= db_cnt_next;
        if (db_cnt_next >= DB_W'(DEBOUNCE)) sensed <= sync2;
        state     <= state_next;
        ing_q     <= ing_next;
        egr_q     <= egr_next;
        // Timer counts cycles since the bay last entered ENTRANDO or SALIENDO.
        if (state_next != state &&
            (state_next == ENTRANDO || state_next == SALIENDO))
          timer <= '0;
        else if (timer < TM_W'(TIMEOUT))
          timer <= timer + 1'b1;
      end
    end

    assign ingreso[i] = ing_q;
    assign egreso[i]  = egr_q;
    assign ocupado[i] = (state == ESTACIONADO) || (state == SALIENDO);
    assign error[i]   = (state == INVALIDO);
  end

  // A new error on the same edge as clr_error keeps the sticky bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_sticky   <= '0;
      ocupados       <= '0;
      total_ingresos <= '0;
    end else begin
      error_sticky   <= (error_sticky & ~{N_BAYS{clr_error}}) | error;
      ocupados       <= popcount(ocupado);
      total_ingresos <= total_ingresos + CNT_W'(popcount(ingreso));
    end
  end

endmodule

// File: tb/tb_sensor_estacionamiento.sv
// Scoreboard bench for sensor_estacionamiento: directed beam sequences push expected
// events; a monitor pops and compares whenever a pulse or an error change appears.
module tb_sensor_estacionamiento;

  localparam int N_BAYS   = 4;
  localparam int DEBOUNCE = 4;
  localparam int TIMEOUT  = 50;
  localparam int CNT_W    = 2;
  localparam int LAT      = DEBOUNCE + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              clr_error;
  logic [N_BAYS-1:0] a, b;
  logic [N_BAYS-1:0] ingreso, egreso, ocupado, error, error_sticky;
  logic [2:0]        ocupados;
  logic [CNT_W-1:0]  total_ingresos;

  sensor_estacionamiento #(
    .N_BAYS(N_BAYS), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .clr_error(clr_error),
    .ingreso(ingreso), .egreso(egreso), .ocupado(ocupado), .error(error),
    .error_sticky(error_sticky), .ocupados(ocupados), .total_ingresos(total_ingresos)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         tol;
    logic [3:0] ing, egr, ocu, err, sticky;
    logic [2:0] ocs;
    logic [1:0] tot;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   stim_k   = 0;
  bit   mon_en   = 1'b0;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // stim_k is the rising edge that first samples the new beam code.
  task automatic applyStimulus(input logic [3:0] na, input logic [3:0] nb);
    @(negedge clk);
    a      = na;
    b      = nb;
    stim_k = cyc + 1;
  endtask

  task automatic holdCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expectEvent(input int lat, input int tol,
                             input logic [3:0] ing, input logic [3:0] egr,
                             input logic [3:0] ocu, input logic [3:0] err,
                             input logic [3:0] sticky, input logic [2:0] ocs,
                             input logic [1:0] tot);
    exp_t e;
    e.cyc = stim_k + lat;  e.tol = tol;
    e.ing = ing;  e.egr = egr;  e.ocu = ocu;  e.err = err;
    e.sticky = sticky;  e.ocs = ocs;  e.tot = tot;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] ocu, input logic [3:0] err,
                             input logic [3:0] sticky, input logic [2:0] ocs,
                             input logic [1:0] tot);
    @(negedge clk);
    checkValue({tag, "_ingreso"},  ingreso,        0);
    checkValue({tag, "_egreso"},   egreso,         0);
    checkValue({tag, "_ocupado"},  ocupado,        ocu);
    checkValue({tag, "_error"},    error,          err);
    checkValue({tag, "_sticky"},   error_sticky,   sticky);
    checkValue({tag, "_ocupados"}, ocupados,       ocs);
    checkValue({tag, "_total"},    total_ingresos, tot);
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clr_error = 1'b1;
    @(negedge clk);
    clr_error = 1'b0;
  endtask

  // Pulse outputs and error changes are checked on their cycle; counters one cycle later.
  initial begin
    exp_t       e;
    logic [3:0] prev_err;
    prev_err = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (ingreso != 0 || egreso != 0 || error != prev_err) begin
        prev_err = error;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_event: ing=%b egr=%b err=%b, expected no event (cycle %0d)",
                   ingreso, egreso, error, cyc);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (cyc >= e.cyc && cyc <= e.cyc + e.tol) n_pass++;
          else $display("[TB] FAIL event_cycle: got %0d, expected %0d..%0d", cyc, e.cyc, e.cyc + e.tol);
          checkValue("ev_ingreso", ingreso, e.ing);
          checkValue("ev_egreso",  egreso,  e.egr);
          checkValue("ev_ocupado", ocupado, e.ocu);
          checkValue("ev_error",   error,   e.err);
          @(negedge clk);
          checkValue("ev_ocupados", ocupados,       e.ocs);
          checkValue("ev_total",    total_ingresos, e.tot);
          checkValue("ev_sticky",   error_sticky,   e.sticky);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;  clr_error = 1'b0;  a = '0;  b = '0;
    holdCycles(2);
    checkOutput("reset", 4'b0000, 4'b0000, 4'b0000, 3'd0, 2'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    holdCycles(5);

    $display("[TB] bay0 entry, aborted exit, exit");
    applyStimulus(4'b0001, 4'b0000); holdCycles(20);
    applyStimulus(4'b0001, 4'b0001);
    expectEvent(LAT, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 3'd1, 2'd1);
    holdCycles(20);
    applyStimulus(4'b0001, 4'b0000); holdCycles(20);
    applyStimulus(4'b0001, 4'b0001); holdCycles(20);
    checkOutput("abort_exit", 4'b0001, 4'b0000, 4'b0000, 3'd1, 2'd1);
    applyStimulus(4'b0001, 4'b0000); holdCycles(20);
    applyStimulus(4'b0000, 4'b0000);
    expectEvent(LAT, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 3'd0, 2'd1);
    holdCycles(20);

    $display("[TB] invalid code and sticky error");
    applyStimulus(4'b0000, 4'b0001);
    expectEvent(LAT, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 3'd0, 2'd1);
    holdCycles(20);
    applyStimulus(4'b0000, 4'b0000);
    expectEvent(LAT, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 3'd0, 2'd1);
    holdCycles(20);
    pulseClear();
    checkOutput("sticky_clear", 4'b0000, 4'b0000, 4'b0000, 3'd0, 2'd1);

    // clr_error lands on the first cycle the new error is visible
    applyStimulus(4'b0000, 4'b0001);
    expectEvent(LAT, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 3'd0, 2'd1);
    holdCycles(LAT + 1);
    clr_error = 1'b1;
    holdCycles(1);
    clr_error = 1'b0;
    holdCycles(12);
    applyStimulus(4'b0000, 4'b0000);
    expectEvent(LAT, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 3'd0, 2'd1);
    holdCycles(20);
    pulseClear();
    checkOutput("sticky_clear2", 4'b0000, 4'b0000, 4'b0000, 3'd0, 2'd1);

    $display("[TB] stalled entry timeout");
    applyStimulus(4'b0001, 4'b0000);
    expectEvent(LAT + TIMEOUT, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 3'd0, 2'd1);
    holdCycles(TIMEOUT + 15);
    applyStimulus(4'b0000, 4'b0000);
    expectEvent(LAT, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 3'd0, 2'd1);
    holdCycles(20);
    pulseClear();

    $display("[TB] simultaneous entries and counter wrap");
    applyStimulus(4'b0110, 4'b0000); holdCycles(20);
    applyStimulus(4'b0110, 4'b0110);
    expectEvent(LAT, 0, 4'b0110, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 3'd2, 2'd3);
    holdCycles(20);
    applyStimulus(4'b0110, 4'b0000); holdCycles(20);
    applyStimulus(4'b0000, 4'b0000);
    expectEvent(LAT, 0, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 3'd0, 2'd3);
    holdCycles(20);
    applyStimulus(4'b1111, 4'b0000); holdCycles(20);
    applyStimulus(4'b1111, 4'b1111);
    expectEvent(LAT, 0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 3'd4, 2'd3);
    holdCycles(20);
    applyStimulus(4'b1111, 4'b0000); holdCycles(20);
    applyStimulus(4'b0000, 4'b0000);
    expectEvent(LAT, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 3'd0, 2'd3);
    holdCycles(20);
    applyStimulus(4'b1000, 4'b0000); holdCycles(20);
    applyStimulus(4'b1000, 4'b1000);
    expectEvent(LAT, 0, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 3'd1, 2'd0);
    holdCycles(20);
    applyStimulus(4'b1000, 4'b0000); holdCycles(20);
    applyStimulus(4'b0000, 4'b0000);
    expectEvent(LAT, 0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 3'd0, 2'd0);
    holdCycles(20);

    $display("[TB] glitches shorter than the debounce window");
    applyStimulus(4'b0001, 4'b0000); holdCycles(DEBOUNCE - 2);
    applyStimulus(4'b0000, 4'b0000); holdCycles(20);
    applyStimulus(4'b0000, 4'b0001); holdCycles(DEBOUNCE - 2);
    applyStimulus(4'b0000, 4'b0000); holdCycles(20);
    checkOutput("glitch", 4'b0000, 4'b0000, 4'b0000, 3'd0, 2'd0);

    $display("[TB] reset during a manoeuvre");
    applyStimulus(4'b0010, 4'b0000); holdCycles(20);
    applyStimulus(4'b0010, 4'b0010);
    expectEvent(LAT, 0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 3'd1, 2'd1);
    holdCycles(20);
    applyStimulus(4'b0110, 4'b0010); holdCycles(20);
    @(negedge clk);
    reset = 1'b1;  a = '0;  b = '0;
    checkOutput("mid_reset", 4'b0000, 4'b0000, 4'b0000, 3'd0, 2'd0);
    reset = 1'b0;
    holdCycles(20);
    // bay2 must be back in VACIO, so 11 now reads as an invalid code, not a completed entry
    applyStimulus(4'b0100, 4'b0100);
    expectEvent(LAT, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 3'd0, 2'd0);
    holdCycles(20);
    applyStimulus(4'b0000, 4'b0000);
    expectEvent(LAT, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 3'd0, 2'd0);
    holdCycles(20);

    checkValue("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
